// File: rtl/ad_pkg.sv
// ad_pkg: shared constants and FSM encoding for the A/D line capture block.
`default_nettype none

package ad_pkg;

   localparam int PIXW = 8;
   localparam int ADRW = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKIP = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/line_ram.sv
// line_ram: one-write, one-registered-read pixel line memory, read-before-write.
`default_nettype none

module line_ram
   import ad_pkg::*;
#(
   parameter int DEPTH = 9
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            we_i,
   input  logic [ADRW-1:0] wr_addr_i,
   input  logic [PIXW-1:0] wr_data_i,
   input  logic            rd_en_i,
   input  logic [ADRW-1:0] rd_addr_i,
   output logic [PIXW-1:0] rd_data_o,
   output logic            rd_valid_o
);

   localparam int              IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADRW-1:0] LAST = ADRW'(DEPTH - 1);

   logic [PIXW-1:0] mem_q [DEPTH];
   logic [PIXW-1:0] rd_data_q;
   logic            rd_valid_q;

   always_ff @(posedge clk_i) begin
      if (we_i && (wr_addr_i <= LAST)) begin
         mem_q[wr_addr_i[IW-1:0]] <= wr_data_i;
      end
   end

   // Nonblocking read of mem_q sees the pre-write contents on a same-address collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) begin
            rd_data_q <= (rd_addr_i <= LAST) ? mem_q[rd_addr_i[IW-1:0]] : '0;
         end
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

`default_nettype wire

// File: rtl/ad_line_capture.sv
// ad_line_capture: captures one line of A/D pixels into a buffer and keeps
// min/max/sum statistics of the most recently completed line.
`default_nettype none

module ad_line_capture
   import ad_pkg::*;
#(
   parameter int LINENUM = 9,
   parameter int SKIP    = 1,
   parameter int SUMW    = 18
) (
   input  logic            adck,
   input  logic            reset,
   input  logic            start,
   input  logic [PIXW-1:0] ad_in,
   input  logic            rd_en,
   input  logic [ADRW-1:0] rd_addr,
   output logic [PIXW-1:0] rd_data,
   output logic            rd_valid,
   output logic            busy,
   output logic            done,
   output logic            line_ok,
   output logic            overrun,
   output logic [PIXW-1:0] pix_min,
   output logic [PIXW-1:0] pix_max,
   output logic [SUMW-1:0] pix_sum
);

   localparam logic [3:0]      SKIP_LD  = (SKIP > 0) ? 4'(SKIP - 1) : 4'd0;
   localparam logic [ADRW-1:0] LAST_PIX = ADRW'(LINENUM - 1);
   localparam state_e          ST_FIRST = (SKIP > 0) ? ST_SKIP : ST_CAPT;

   state_e          state_q, state_d;
   logic [3:0]      skip_q, skip_d;
   logic [ADRW-1:0] pix_q, pix_d;
   logic [PIXW-1:0] wmin_q, wmin_d, wmax_q, wmax_d;
   logic [SUMW-1:0] wsum_q, wsum_d;
   logic [PIXW-1:0] min_q, min_d, max_q, max_d;
   logic [SUMW-1:0] sum_q, sum_d;
   logic            line_ok_q, line_ok_d;
   logic            overrun_q, overrun_d;
   logic            we;

   always_ff @(posedge adck or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         skip_q    <= '0;
         pix_q     <= '0;
         wmin_q    <= '0;
         wmax_q    <= '0;
         wsum_q    <= '0;
         min_q     <= '0;
         max_q     <= '0;
         sum_q     <= '0;
         line_ok_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         skip_q    <= skip_d;
         pix_q     <= pix_d;
         wmin_q    <= wmin_d;
         wmax_q    <= wmax_d;
         wsum_q    <= wsum_d;
         min_q     <= min_d;
         max_q     <= max_d;
         sum_q     <= sum_d;
         line_ok_q <= line_ok_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      pix_d     = pix_q;
      wmin_d    = wmin_q;
      wmax_d    = wmax_q;
      wsum_d    = wsum_q;
      min_d     = min_q;
      max_d     = max_q;
      sum_d     = sum_q;
      line_ok_d = line_ok_q;
      overrun_d = overrun_q;
      we        = 1'b0;

      // A start outside IDLE never restarts the capture; it only flags the collision.
      if (start && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FIRST;
               skip_d    = SKIP_LD;
               pix_d     = '0;
               wmin_d    = '1;
               wmax_d    = '0;
               wsum_d    = '0;
               line_ok_d = 1'b0;
            end
         end
         ST_SKIP: begin
            if (skip_q == 4'd0) begin
               state_d = ST_CAPT;
            end else begin
               skip_d = skip_q - 4'd1;
            end
         end
         ST_CAPT: begin
            we     = 1'b1;
            wmin_d = (ad_in < wmin_q) ? ad_in : wmin_q;
            wmax_d = (ad_in > wmax_q) ? ad_in : wmax_q;
            wsum_d = wsum_q + SUMW'(ad_in);
            if (pix_q == LAST_PIX) begin
               state_d = ST_DONE;
            end else begin
               pix_d = pix_q + ADRW'(1);
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            min_d     = wmin_q;
            max_d     = wmax_q;
            sum_d     = wsum_q;
            line_ok_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   line_ram #(
      .DEPTH (LINENUM)
   ) u_line_ram (
      .clk_i      (adck),
      .rst_ni     (reset),
      .we_i       (we),
      .wr_addr_i  (pix_q),
      .wr_data_i  (ad_in),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid)
   );

   assign busy    = (state_q == ST_SKIP) || (state_q == ST_CAPT);
   assign done    = (state_q == ST_DONE);
   assign line_ok = line_ok_q;
   assign overrun = overrun_q;
   assign pix_min = min_q;
   assign pix_max = max_q;
   assign pix_sum = sum_q;

endmodule

`default_nettype wire
